// File: rtl/ks_add_sequencer_pkg.sv
// rtl/ks_add_sequencer_pkg.sv - shared types and constants for the multi-precision add sequencer
package ks_add_sequencer_pkg;

  localparam int NREQ_DEFAULT  = 2;
  localparam int WORDS_DEFAULT = 4;

  // Registered S/Co of the shared adder: result byte k-ADD_LAT arrives while byte k is issued.
  localparam int ADD_LAT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAST = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Width of an index into n items, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ks_add_sequencer_rr_arbiter.sv
// rtl/ks_add_sequencer_rr_arbiter.sv - combinational round-robin grant search from a priority pointer
module rr_arbiter
  import ks_add_sequencer_pkg::*;
#(
  parameter int  NREQ = NREQ_DEFAULT,
  localparam int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  id_o
);

  int   idx;
  logic found;

  // Walk upward from the pointer, wrapping, and grant the first active request.
  always_comb begin
    grant_o = '0;
    id_o    = '0;
    found   = 1'b0;
    idx     = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(ptr_i) + off) % NREQ;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        id_o         = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/ks_add_sequencer.sv
// rtl/ks_add_sequencer.sv - byte-serial multi-precision add sequencer in front of a shared registered adder
module ks_add_sequencer
  import ks_add_sequencer_pkg::*;
#(
  parameter int  NREQ  = NREQ_DEFAULT,
  parameter int  WORDS = WORDS_DEFAULT,
  localparam int OPW   = 8 * WORDS,
  localparam int IDW   = id_width(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*OPW-1:0] req_a,
  input  logic [NREQ*OPW-1:0] req_b,
  input  logic [NREQ-1:0]     req_ci,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [IDW-1:0]      resp_id,
  output logic [OPW-1:0]      resp_sum,
  output logic                resp_co,
  output logic                busy,
  output logic [7:0]          add_a,
  output logic [7:0]          add_b,
  output logic                add_ci,
  input  logic [7:0]          add_s,
  input  logic                add_co
);

  localparam int KW = id_width(WORDS);

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q;
  logic [OPW-1:0]  a_q, b_q, result_q;
  logic            ci_q, co_q;
  logic [IDW-1:0]  id_q, ptr_q;

  logic [NREQ-1:0] arb_grant;
  logic [IDW-1:0]  arb_id;
  logic            arb_any;
  logic            last_byte;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .id_o    (arb_id)
  );

  assign arb_any   = |arb_grant;
  assign last_byte = (k_q == KW'(WORDS - 1));

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state: accept, one cycle per byte, one drain cycle for the adder latency, then respond.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (arb_any)    state_d = ST_RUN;
      ST_RUN:  if (last_byte)  state_d = ST_LAST;
      ST_LAST:                 state_d = ST_RESP;
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Outputs: grant only while idle, adder fed only in RUN with the carry chained back in.
  always_comb begin
    req_ready  = '0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    add_a      = '0;
    add_b      = '0;
    add_ci     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy      = 1'b0;
        // Keep the grant quiet while reset is asserted so every output reads zero.
        req_ready = arb_grant & {NREQ{rst}};
      end
      ST_RUN: begin
        for (int w = 0; w < WORDS; w++) begin
          if (k_q == KW'(w)) begin
            add_a = a_q[8*w +: 8];
            add_b = b_q[8*w +: 8];
          end
        end
        add_ci = (k_q == '0) ? ci_q : add_co;
      end
      ST_RESP: resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: latch operands on accept, collect lagging adder bytes, advance the pointer on handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ci_q     <= 1'b0;
      id_q     <= '0;
      ptr_q    <= '0;
      result_q <= '0;
      co_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            for (int i = 0; i < NREQ; i++) begin
              if (arb_grant[i]) begin
                a_q  <= req_a[OPW*i +: OPW];
                b_q  <= req_b[OPW*i +: OPW];
                ci_q <= req_ci[i];
              end
            end
            id_q <= arb_id;
            k_q  <= '0;
          end
        end
        ST_RUN: begin
          for (int w = 0; w < WORDS - 1; w++) begin
            if (k_q == KW'(w + ADD_LAT)) result_q[8*w +: 8] <= add_s;
          end
          if (!last_byte) k_q <= k_q + KW'(1);
        end
        ST_LAST: begin
          result_q[OPW-8 +: 8] <= add_s;
          co_q                 <= add_co;
        end
        ST_RESP: begin
          if (resp_ready) ptr_q <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
        end
        default: ;
      endcase
    end
  end

  assign resp_sum = result_q;
  assign resp_co  = co_q;
  assign resp_id  = id_q;

endmodule

// File: tb/tb_ks_add_sequencer.sv
// tb/tb_ks_add_sequencer.sv - randomized self-checking bench for ks_add_sequencer
module tb_ks_add_sequencer;

  localparam int NREQ = 2;
  localparam int WORDS = 4;
  localparam int OPW = 8 * WORDS;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*OPW-1:0] req_a = '0;
  logic [NREQ*OPW-1:0] req_b = '0;
  logic [NREQ-1:0]     req_ci = '0;
  logic                resp_valid;
  logic                resp_ready = 1'b0;
  logic [0:0]          resp_id;
  logic [OPW-1:0]      resp_sum;
  logic                resp_co;
  logic                busy;
  logic [7:0]          add_a, add_b;
  logic                add_ci;
  logic [7:0]          add_s = '0;
  logic                add_co = 1'b0;

  int checks = 0;
  int failures = 0;
  int tb_ptr = 0;

  ks_add_sequencer #(.NREQ(NREQ), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ci(req_ci),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_sum(resp_sum), .resp_co(resp_co),
    .busy(busy),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
    .add_s(add_s), .add_co(add_co)
  );

  always #5 clk = ~clk;

  // Shared adder stand-in: 8-bit add with registered sum and carry.
  always @(posedge clk) {add_co, add_s} <= {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_ci};

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  function automatic int model_grant(input logic [NREQ-1:0] v, input int p);
    for (int o = 0; o < NREQ; o++) if (v[(p + o) % NREQ]) return (p + o) % NREQ;
    return -1;
  endfunction

  function automatic logic [OPW:0] model_sum(input int r);
    logic [OPW-1:0] a, b;
    a = req_a[r*OPW +: OPW];
    b = req_b[r*OPW +: OPW];
    return {1'b0, a} + {1'b0, b} + {{OPW{1'b0}}, req_ci[r]};
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int r);
    logic [NREQ-1:0] v;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  task automatic set_ops(input int r, input logic [OPW-1:0] a, input logic [OPW-1:0] b, input logic ci);
    req_a[r*OPW +: OPW] = a;
    req_b[r*OPW +: OPW] = b;
    req_ci[r] = ci;
  endtask

  task automatic apply_reset();
    req_valid = '0;
    resp_ready = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tb_ptr = 0;
  endtask

  // Drive one transaction to completion and report what the DUT did; entered and left at #1 after an edge.
  task automatic serve(input bit drop, input bit scramble, output logic [NREQ-1:0] gnt, output int lat,
                       output logic [OPW:0] res, output int rid, output bit to);
    int n;
    n = 0; to = 0; gnt = '0; lat = 0; res = '0; rid = -1;
    #1;
    while (req_ready == '0 && n < 40) begin @(posedge clk); #2; n++; end
    if (req_ready == '0) begin to = 1; return; end
    gnt = req_ready;
    @(posedge clk); #1;
    if (drop) req_valid = req_valid & ~gnt;
    if (scramble) begin
      for (int i = 0; i < NREQ; i++) set_ops(i, OPW'($urandom), OPW'($urandom), 1'($urandom));
    end
    while (!resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!resp_valid) begin to = 1; return; end
    res = {resp_co, resp_sum};
    rid = int'(resp_id);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [NREQ+OPW+21:0] outs;
    #3 rst = 1'b0;
    req_valid = '1;
    #2;
    outs = {req_ready, resp_valid, resp_sum, resp_co, resp_id, busy, add_a, add_b, add_ci};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", outs); end
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    tb_ptr = 0;
    #1;
    checks++;
    if (busy !== 1'b0 || req_ready !== '0) begin
      failures++; $display("FAIL reset_idle busy=%b req_ready=%b exp 0/0", busy, req_ready);
    end
  endtask

  task automatic test_single();
    logic [NREQ-1:0] gnt; int lat, rid; logic [OPW:0] res; bit to;
    set_ops(0, 32'h000000FF, 32'h00000001, 1'b0);
    req_valid = 2'b01;
    serve(1, 0, gnt, lat, res, rid, to);
    checks++;
    if (to) begin failures++; $display("FAIL single_timeout no response"); return; end
    tb_ptr = 1;
    checks++;
    if (res !== 33'h000000100) begin failures++; $display("FAIL single_sum got=%h exp=%h", res, 33'h000000100); end
    checks++;
    if (rid !== 0 || gnt !== 2'b01) begin failures++; $display("FAIL single_id got=%0d/%b exp=0/01", rid, gnt); end
    checks++;
    if (lat !== WORDS + 1) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", lat, WORDS + 1); end
  endtask

  task automatic test_carry();
    logic [NREQ-1:0] gnt; int lat, rid, rq; logic [OPW:0] res, exp; bit to;
    for (int i = 0; i < 8; i++) begin
      rq = i % 2;
      if (i == 0)      set_ops(rq, 32'hFFFFFFFF, 32'h00000000, 1'b1);
      else if (i == 1) set_ops(rq, 32'h12345678, 32'h9ABCDEF0, 1'b0);
      else             set_ops(rq, OPW'($urandom), OPW'($urandom), 1'($urandom));
      exp = model_sum(rq);
      req_valid = onehot(rq);
      serve(1, 0, gnt, lat, res, rid, to);
      checks++;
      if (to) begin failures++; $display("FAIL carry_timeout vec=%0d", i); return; end
      tb_ptr = (rq + 1) % NREQ;
      checks++;
      if (res !== exp || rid !== rq) begin
        failures++; $display("FAIL carry_sum vec=%0d got=%h id=%0d exp=%h id=%0d", i, res, rid, exp, rq);
      end
    end
  endtask

  task automatic test_arbitration();
    logic [NREQ-1:0] gnt; int lat, rid, eg; logic [OPW:0] res, exp; bit to;
    apply_reset();
    for (int r = 0; r < NREQ; r++) set_ops(r, OPW'($urandom), OPW'($urandom), 1'($urandom));
    req_valid = '1;
    for (int i = 0; i < 4; i++) begin
      eg = model_grant(req_valid, tb_ptr);
      exp = model_sum(eg);
      serve(0, 0, gnt, lat, res, rid, to);
      if (i == 3) req_valid = '0;
      checks++;
      if (to) begin failures++; $display("FAIL arb_timeout txn=%0d", i); req_valid = '0; return; end
      tb_ptr = (eg + 1) % NREQ;
      checks++;
      if (rid !== i % 2 || gnt !== onehot(eg)) begin
        failures++; $display("FAIL arb_order txn=%0d got=%0d/%b exp=%0d", i, rid, gnt, i % 2);
      end
      checks++;
      if (res !== exp) begin failures++; $display("FAIL arb_sum txn=%0d got=%h exp=%h", i, res, exp); end
    end
  endtask

  task automatic test_backpressure();
    logic [OPW:0] exp; int n, eg;
    set_ops(0, OPW'($urandom), OPW'($urandom), 1'($urandom));
    exp = model_sum(0);
    req_valid = 2'b01;
    eg = model_grant(req_valid, tb_ptr);
    n = 0;
    #1;
    while (!resp_valid && n < 40) begin @(posedge clk); #2; n++; end
    checks++;
    if (!resp_valid) begin failures++; $display("FAIL bp_timeout no response"); req_valid = '0; return; end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (resp_valid !== 1'b1 || {resp_co, resp_sum} !== exp || int'(resp_id) !== eg) begin
        failures++; $display("FAIL bp_hold cyc=%0d valid=%b got=%h id=%0d exp=%h id=%0d",
                             c, resp_valid, {resp_co, resp_sum}, resp_id, exp, eg);
      end
      checks++;
      if (req_ready !== '0 || busy !== 1'b1) begin
        failures++; $display("FAIL bp_no_accept cyc=%0d req_ready=%b busy=%b exp 00/1", c, req_ready, busy);
      end
      @(posedge clk); #2;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    tb_ptr = (eg + 1) % NREQ;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 2'b01) begin
      failures++; $display("FAIL bp_release valid=%b req_ready=%b exp 0/01", resp_valid, req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    logic [NREQ-1:0] gnt; int lat, rid, n, seen; logic [OPW:0] res; bit to;
    logic [NREQ+OPW+21:0] outs;
    set_ops(0, OPW'($urandom), OPW'($urandom), 1'b1);
    req_valid = 2'b01;
    n = 0;
    #1;
    while (req_ready == '0 && n < 40) begin @(posedge clk); #2; n++; end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (busy !== 1'b1 || add_a !== req_a[23:16]) begin
      failures++; $display("FAIL midrst_run busy=%b add_a=%h exp 1/%h", busy, add_a, req_a[23:16]);
    end
    rst = 1'b0;
    #1;
    outs = {req_ready, resp_valid, resp_sum, resp_co, resp_id, busy, add_a, add_b, add_ci};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL midrst_outputs got=%h exp=0", outs); end
    @(posedge clk); #1;
    rst = 1'b1;
    tb_ptr = 0;
    seen = 0;
    repeat (10) begin @(posedge clk); #1; if (resp_valid) seen++; end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL midrst_no_resp got=%0d exp=0", seen); end
    set_ops(1, 32'h80000000, 32'h80000000, 1'b0);
    req_valid = 2'b10;
    serve(1, 0, gnt, lat, res, rid, to);
    checks++;
    if (to) begin failures++; $display("FAIL midrst_timeout no response"); return; end
    tb_ptr = 0;
    checks++;
    if (res !== {1'b1, 32'h0} || rid !== 1) begin
      failures++; $display("FAIL midrst_sum got=%h id=%0d exp=%h id=1", res, rid, {1'b1, 32'h0});
    end
  endtask

  task automatic test_operand_change();
    logic [NREQ-1:0] gnt; int lat, rid, rq; logic [OPW:0] res, exp; bit to;
    for (int i = 0; i < 4; i++) begin
      rq = $urandom_range(0, NREQ - 1);
      set_ops(rq, OPW'($urandom), OPW'($urandom), 1'($urandom));
      exp = model_sum(rq);
      req_valid = onehot(rq);
      serve(1, 1, gnt, lat, res, rid, to);
      checks++;
      if (to) begin failures++; $display("FAIL opchg_timeout txn=%0d", i); return; end
      tb_ptr = (rq + 1) % NREQ;
      checks++;
      if (res !== exp || rid !== rq) begin
        failures++; $display("FAIL opchg_sum txn=%0d got=%h id=%0d exp=%h id=%0d", i, res, rid, exp, rq);
      end
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] gnt; int lat, rid, eg; logic [OPW:0] res, exp; bit to;
    for (int i = 0; i < 20; i++) begin
      req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int r = 0; r < NREQ; r++) set_ops(r, OPW'($urandom), OPW'($urandom), 1'($urandom));
      eg = model_grant(req_valid, tb_ptr);
      exp = model_sum(eg);
      serve(1, 0, gnt, lat, res, rid, to);
      checks++;
      if (to) begin failures++; $display("FAIL rand_timeout txn=%0d", i); req_valid = '0; return; end
      tb_ptr = (eg + 1) % NREQ;
      checks++;
      if (gnt !== onehot(eg) || rid !== eg) begin
        failures++; $display("FAIL rand_grant txn=%0d got=%b id=%0d exp id=%0d", i, gnt, rid, eg);
      end
      checks++;
      if (res !== exp) begin failures++; $display("FAIL rand_sum txn=%0d got=%h exp=%h", i, res, exp); end
      checks++;
      if (lat !== WORDS + 1) begin failures++; $display("FAIL rand_latency txn=%0d got=%0d exp=%0d", i, lat, WORDS + 1); end
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_carry();
    test_arbitration();
    test_backpressure();
    test_reset_mid();
    test_operand_change();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
